// File: rtl/pcm_capture_fifo.sv
// pcm_capture_fifo
//   Capture buffer placed right after the PCM clock divider. Every 0->1
//   transition of the divider's we_pcm toggle latches pcm_in into a circular
//   FIFO. Samples are drained over a show-ahead valid/ready port. A sample
//   that arrives while the FIFO is full and not being popped is dropped, and
//   a sticky overflow flag is set.
//
// Ports
//   clk, rst   system clock; asynchronous active-high reset
//   we_pcm     divider toggle output (each rising edge is one sample event)
//   pcm_in     sample word, captured on a sample event
//   en         capture enable (reads are unaffected)
//   clear      synchronous flush of contents, level and overflow
//   rd_valid   head entry available
//   rd_data    head entry (combinational from storage)
//   rd_ready   consumer accepts head entry
//   level      entries stored, 0..2^AW
//   full       level == 2^AW
//   empty      level == 0
//   overflow   sticky: a sample was dropped since reset/clear
module pcm_capture_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_pcm,
    input  logic [DW-1:0] pcm_in,
    input  logic          en,
    input  logic          clear,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_ready,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int            DEPTH = 1 << AW;
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          we_pcm_d;

    logic ev;
    logic pop;
    logic wr;

    // Flags depend only on registered level, never on rd_ready or we_pcm.
    assign full     = (level == LEVEL_FULL);
    assign empty    = (level == '0);
    assign rd_valid = ~empty;
    assign rd_data  = mem[rd_ptr];

    assign ev  = we_pcm & ~we_pcm_d & en;
    assign pop = rd_valid & rd_ready;
    // A pop on the same cycle frees a slot, so a full FIFO still accepts.
    assign wr  = ev & (~full | pop);

    // we_pcm_d resets high so a level already high at reset release is not
    // mistaken for an edge; it keeps tracking through en=0 and clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_pcm_d <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            we_pcm_d <= we_pcm;
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (wr && !pop)
                    level <= level + (AW+1)'(1);
                else if (pop && !wr)
                    level <= level - (AW+1)'(1);
                if (ev && full && !pop)
                    overflow <= 1'b1;
            end
        end
    end

    // Sample storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr && !clear && !rst)
            mem[wr_ptr] <= pcm_in;
    end

endmodule

// File: doc/pcm_capture_fifo.md
# pcm_capture_fifo

Sample-capture buffer directly downstream of the PCM clock divider. Detects each rising edge of the divider's `we_pcm` toggle output, latches the current PCM word into a circular FIFO, and presents buffered samples to the processing/readout side over a valid/ready interface. Overruns are counted as dropped samples and flagged sticky, so the sonar back-end can detect lost echo data.

## Interface
- `DW`, 16, PCM sample width in bits
- `AW`, 4, FIFO address width; depth = 2^AW entries

- `clk`  in  1  system clock, same domain as the divider
- `rst`  in  1  asynchronous, active-high reset
- `we_pcm`  in  1  divider output; level toggles, each 0->1 transition is one sample event
- `pcm_in`  in  DW  PCM sample word, valid whenever a sample event occurs
- `en`  in  1  capture enable; 0 suppresses writes, reads continue
- `clear`  in  1  synchronous flush of FIFO contents and flags
- `rd_valid`  out  1  head entry available
- `rd_data`  out  DW  head entry (show-ahead)
- `rd_ready`  in  1  consumer accepts head entry
- `level`  out  AW+1  entries currently stored, 0..2^AW
- `full`  out  1  level == 2^AW
- `empty`  out  1  level == 0
- `overflow`  out  1  sticky: at least one sample dropped since reset/clear

## Operation
- Edge detect: register `we_pcm_d <= we_pcm`; sample event `ev = we_pcm & ~we_pcm_d & en`.
- `we_pcm_d` resets to 1: `we_pcm` high at reset release does NOT produce a spurious sample.
- Storage: register array of 2^AW x DW; `wr_ptr`, `rd_ptr` AW bits, wrap modulo 2^AW; `level` held as separate AW+1 counter (or AW+1-bit pointers); no other state.
- Write: `ev & ~full` -> `mem[wr_ptr] <= pcm_in`, `wr_ptr++`.
- Drop: `ev & full & ~pop` -> sample discarded, `overflow <= 1`; pointers unchanged.
- Read: `pop = rd_valid & rd_ready` -> `rd_ptr++`. `rd_valid = ~empty`; `rd_data = mem[rd_ptr]`, combinational from array.
- Simultaneous `ev` and `pop`:
  - when full, write is accepted (slot freed same cycle); level stays 2^AW; no overflow.
  - when empty, pop cannot occur (rd_valid=0); write proceeds.
  - otherwise level unchanged, both pointers advance.
- `clear` (highest priority): `wr_ptr`, `rd_ptr`, `level`, `overflow` <= 0; any coincident write or pop is ignored. `we_pcm_d` still updates normally.
- `en` low: `we_pcm_d` keeps tracking, so an edge occurring while disabled is never captured late when `en` returns high.
- `rd_data` is don't-care while `rd_valid`=0; memory contents are not reset.

## Timing
- Reset values: `rd_valid`=0, `level`=0, `full`=0, `empty`=1, `overflow`=0, pointers 0, `we_pcm_d`=1; `rd_data` undefined.
- Sample event decoded in cycle N (`we_pcm`=1 at edge N, 0 at edge N-1); `pcm_in` captured at edge N; `rd_valid`/`level` update visible after edge N (write-to-read latency 1 cycle, no bypass).
- Pop at edge N: next entry on `rd_data` and updated `level` after edge N; back-to-back pops at one per cycle sustained.
- `full`, `empty`, `rd_valid` are decoded from registered state only, with no combinational path from `rd_ready` or `we_pcm`.
- With divider count C, events arrive every 2*C clocks; the FIFO must accept them at any rate down to one event every 2 cycles.
- Async `rst` mid-operation: all state returns to reset values immediately; first event after release requires a fresh 0->1 of `we_pcm`.

## Test plan
- Basic capture: DW=16, AW=4, `en`=1, `rd_ready`=0; toggle `we_pcm` with `pcm_in`=0x1111,0x2222,0x3333 at each rise -> `level`=3, `rd_valid`=1 one cycle after first rise; assert `rd_ready` -> reads 0x1111,0x2222,0x3333 in order, then `empty`=1.
- Falling edges ignored: hold `we_pcm` high 5 cycles then low 5 cycles -> exactly one entry written per full period.
- Overflow: 17 events, no reads -> `full`=1 after 16th, 17th dropped, `overflow`=1, `level`=16; head still sample 1; `clear` -> `level`=0, `overflow`=0, `empty`=1.
- Full plus simultaneous pop: fill 16, assert `rd_ready` on the event cycle -> `level` stays 16, `overflow` stays 0, last entry equals new sample.
- Reset with `we_pcm` high: deassert `rst` while `we_pcm`=1 -> no write; next 0->1 writes one entry.
- `en` gating and wrap: `en`=0 across 3 edges -> `level` unchanged; then 40 events with continuous `rd_ready`=1 -> all 40 samples read in order across pointer wrap, `overflow`=0.
